// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo: write side, read side and status flags.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_wr;
  logic                  wr_en;
  logic                  fifo_full;
  logic [DATA_WIDTH-1:0] data_rd;
  logic                  rd_en;
  logic                  fifo_empty;

  modport master (
    output data_wr, wr_en, rd_en,
    input  data_rd, fifo_full, fifo_empty
  );

  modport slave (
    input  data_wr, wr_en, rd_en,
    output data_rd, fifo_full, fifo_empty
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO of DEPTH words (any DEPTH >= 2), with an optional registered read stage
// (RD_BUFFER=1) or first-word fall-through head view (RD_BUFFER=0).
module sync_fifo #(
  parameter int DEPTH      = 12,
  parameter int DATA_WIDTH = 8,
  parameter bit RD_BUFFER  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  sync_fifo_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;

  assign full   = (count_q == CNT_FULL);
  assign empty  = (count_q == '0);
  assign wr_acc = bus.wr_en & ~full;
  assign rd_acc = bus.rd_en & ~empty;

  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;

  // Pointers wrap by explicit compare so non-power-of-two depths stay contiguous.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= bus.data_wr;
    end
  end

  generate
    if (RD_BUFFER) begin : g_rd_reg
      logic [DATA_WIDTH-1:0] data_rd_q, data_rd_d;

      always_comb begin
        data_rd_d = data_rd_q;
        if (rd_acc) begin
          data_rd_d = mem_q[rd_ptr_q];
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_rd_q <= '0;
        end else begin
          data_rd_q <= data_rd_d;
        end
      end

      assign bus.data_rd = data_rd_q;
    end else begin : g_rd_fwft
      assign bus.data_rd = mem_q[rd_ptr_q];
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench driving a registered-read and a fall-through sync_fifo with identical stimulus.
module tb_sync_fifo;
  localparam int DEPTH = 12;
  localparam int DW    = 8;

  logic clk;
  logic rst;

  sync_fifo_if #(.DATA_WIDTH(DW)) if_b ();
  sync_fifo_if #(.DATA_WIDTH(DW)) if_u ();

  sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .RD_BUFFER(1'b1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .RD_BUFFER(1'b0)) dut_u (
    .clk (clk),
    .rst (rst),
    .bus (if_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] last_b;

  logic          rd_acc_s;
  logic [DW-1:0] obs_u, exp_u;
  logic [DW-1:0] obs_b, exp_b;
  logic [3:0]    obs_flags, exp_flags;

  // One clock: entered and left at posedge+1. Expected values come from q / last_b only.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    logic wacc, racc;
    if_b.wr_en = w; if_b.rd_en = r; if_b.data_wr = d;
    if_u.wr_en = w; if_u.rd_en = r; if_u.data_wr = d;
    wacc = w && (q.size() < DEPTH);
    racc = r && (q.size() > 0);
    rd_acc_s = racc;
    exp_u = racc ? q[0] : '0;
    #8;
    obs_u = if_u.data_rd;
    @(posedge clk);
    #1;
    if (racc) last_b = q.pop_front();
    if (wacc) q.push_back(d);
    obs_b     = if_b.data_rd;
    exp_b     = last_b;
    obs_flags = {if_b.fifo_full, if_b.fifo_empty, if_u.fifo_full, if_u.fifo_empty};
    exp_flags = {2{(q.size() == DEPTH), (q.size() == 0)}};
    if_b.wr_en = 1'b0; if_b.rd_en = 1'b0;
    if_u.wr_en = 1'b0; if_u.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_b.wr_en = 1'b0; if_b.rd_en = 1'b0; if_b.data_wr = '0;
    if_u.wr_en = 1'b0; if_u.rd_en = 1'b0; if_u.data_wr = '0;
    q.delete();
    last_b = '0;
    #2;
    vectors++;
    if ({if_b.fifo_full, if_b.fifo_empty, if_u.fifo_full, if_u.fifo_empty} !== 4'b0101) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0101",
               {if_b.fifo_full, if_b.fifo_empty, if_u.fifo_full, if_u.fifo_empty});
    end
    vectors++;
    if (if_b.data_rd !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data_rd: got %h want 00", if_b.data_rd);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({if_b.fifo_full, if_b.fifo_empty, if_u.fifo_full, if_u.fifo_empty} !== 4'b0101) begin
      miscompares++;
      $display("FAIL reset_idle_flags: got %b want 0101",
               {if_b.fifo_full, if_b.fifo_empty, if_u.fifo_full, if_u.fifo_empty});
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH + 3; i++) begin
      step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
      vectors++;
      if (obs_flags !== exp_flags) begin
        miscompares++;
        $display("FAIL fill_flags write %0d: got %b want %b", i, obs_flags, exp_flags);
      end
      vectors++;
      if (obs_b !== exp_b) begin
        miscompares++;
        $display("FAIL fill_data_hold write %0d: got %h want %h", i, obs_b, exp_b);
      end
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH + 3; i++) begin
      step(1'b0, 1'b1, '0);
      vectors++;
      if (obs_flags !== exp_flags) begin
        miscompares++;
        $display("FAIL drain_flags read %0d: got %b want %b", i, obs_flags, exp_flags);
      end
      vectors++;
      if (obs_b !== exp_b) begin
        miscompares++;
        $display("FAIL drain_data_b read %0d: got %h want %h", i, obs_b, exp_b);
      end
      if (rd_acc_s) begin
        vectors++;
        if (obs_u !== exp_u) begin
          miscompares++;
          $display("FAIL drain_data_u read %0d: got %h want %h", i, obs_u, exp_u);
        end
      end
    end
  endtask

  task automatic test_interleave();
    int unsigned bursts[4] = '{7, 5, 9, 11};
    for (int b = 0; b < 4; b++) begin
      for (int unsigned i = 0; i < bursts[b]; i++) begin
        step((b % 2) == 0, (b % 2) == 1, 8'($urandom_range(0, 255)));
        vectors++;
        if (obs_flags !== exp_flags) begin
          miscompares++;
          $display("FAIL interleave_flags burst %0d op %0d: got %b want %b", b, i, obs_flags, exp_flags);
        end
        vectors++;
        if (obs_b !== exp_b) begin
          miscompares++;
          $display("FAIL interleave_data_b burst %0d op %0d: got %h want %h", b, i, obs_b, exp_b);
        end
        if (rd_acc_s) begin
          vectors++;
          if (obs_u !== exp_u) begin
            miscompares++;
            $display("FAIL interleave_data_u burst %0d op %0d: got %h want %h", b, i, obs_u, exp_u);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH + 1; i++) begin
      // Final iteration drains the one word left in flight.
      step(i < DEPTH, 1'b1, 8'($urandom_range(0, 255)));
      vectors++;
      if (obs_flags !== exp_flags) begin
        miscompares++;
        $display("FAIL b2b_flags cycle %0d: got %b want %b", i, obs_flags, exp_flags);
      end
      vectors++;
      if (obs_b !== exp_b) begin
        miscompares++;
        $display("FAIL b2b_data_b cycle %0d: got %h want %h", i, obs_b, exp_b);
      end
      if (rd_acc_s) begin
        vectors++;
        if (obs_u !== exp_u) begin
          miscompares++;
          $display("FAIL b2b_data_u cycle %0d: got %h want %h", i, obs_u, exp_u);
        end
      end
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    vectors++;
    if (obs_flags !== 4'b1010) begin
      miscompares++;
      $display("FAIL fullrw_full_flags: got %b want 1010", obs_flags);
    end
    step(1'b1, 1'b1, 8'hA5);
    vectors++;
    if (obs_flags !== 4'b0000) begin
      miscompares++;
      $display("FAIL fullrw_flags_after: got %b want 0000", obs_flags);
    end
    vectors++;
    if (obs_b !== exp_b) begin
      miscompares++;
      $display("FAIL fullrw_head_b: got %h want %h", obs_b, exp_b);
    end
    vectors++;
    if (obs_u !== exp_u) begin
      miscompares++;
      $display("FAIL fullrw_head_u: got %h want %h", obs_u, exp_u);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, '0);
      vectors++;
      if ({obs_flags, obs_b} !== {exp_flags, exp_b}) begin
        miscompares++;
        $display("FAIL fullrw_drain read %0d: got %b/%h want %b/%h", i, obs_flags, obs_b, exp_flags, exp_b);
      end
      if (rd_acc_s) begin
        vectors++;
        if (obs_u !== exp_u) begin
          miscompares++;
          $display("FAIL fullrw_drain_u read %0d: got %h want %h", i, obs_u, exp_u);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step(1'b1, i > 2, 8'($urandom_range(0, 255)));
    #3;
    rst = 1'b0;
    q.delete();
    last_b = '0;
    #1;
    vectors++;
    if ({if_b.fifo_full, if_b.fifo_empty, if_u.fifo_full, if_u.fifo_empty} !== 4'b0101) begin
      miscompares++;
      $display("FAIL arst_flags: got %b want 0101",
               {if_b.fifo_full, if_b.fifo_empty, if_u.fifo_full, if_u.fifo_empty});
    end
    vectors++;
    if (if_b.data_rd !== 8'h00) begin
      miscompares++;
      $display("FAIL arst_data_rd: got %h want 00", if_b.data_rd);
    end
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      step(i < 3, i >= 3, 8'(8'h30 + i));
      vectors++;
      if ({obs_flags, obs_b} !== {exp_flags, exp_b}) begin
        miscompares++;
        $display("FAIL arst_resume op %0d: got %b/%h want %b/%h", i, obs_flags, obs_b, exp_flags, exp_b);
      end
      if (rd_acc_s) begin
        vectors++;
        if (obs_u !== exp_u) begin
          miscompares++;
          $display("FAIL arst_resume_u op %0d: got %h want %h", i, obs_u, exp_u);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_interleave();
    test_back_to_back();
    test_full_rw();
    test_async_reset();
    test_reset();
    test_fill();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
